// File: rtl/rf_pkg.sv
// rf_pkg: shared widths and FSM state encoding for the register-file read scheduler
package rf_pkg;
    localparam int RF_IDX_W  = 5;
    localparam int RF_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} rf_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starts at ptr and wraps
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] idx;
    // walk offsets from farthest to nearest so the nearest requester overwrites the grant
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_read_sched.sv
// rf_read_sched: arbitrates requesters onto a shared register-file read port and returns masked data
module rf_read_sched
    import rf_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int TO_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [RF_IDX_W*NREQ-1:0] req_rs1,
    input  logic [RF_IDX_W*NREQ-1:0] req_rs2,
    input  logic [NREQ-1:0]          req_two,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_read_en,
    output logic [RF_IDX_W-1:0]      rf_selrs1,
    output logic [RF_IDX_W-1:0]      rf_selrs2,
    output logic                     rf_reg_select,
    input  logic [RF_DATA_W-1:0]     rf_data1,
    input  logic [RF_DATA_W-1:0]     rf_data2,
    input  logic                     rf_complete,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [RF_DATA_W-1:0]     rsp_data1,
    output logic [RF_DATA_W-1:0]     rsp_data2,
    output logic                     rsp_err,
    output logic                     busy
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TO_CYC + 1);

    rf_state_t     state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;
    logic [NREQ-1:0] gnt;
    logic [CW-1:0] cnt;

    rr_arbiter #(.N(NREQ)) u_arb (.req(req_valid), .ptr(ptr), .gnt(gnt));

    // encode the one-hot grant into a requester index
    always_comb begin
        gidx = '0;
        for (int k = 0; k < NREQ; k++)
            if (gnt[k]) gidx = IW'(k);
    end

    assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
    assign busy      = state != IDLE;

    // the select registers double as the latched request while in ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            rf_read_en    <= 1'b0;
            rf_selrs1     <= '0;
            rf_selrs2     <= '0;
            rf_reg_select <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_data1     <= '0;
            rsp_data2     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    state         <= ISSUE;
                    ptr           <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    cnt           <= '0;
                    rf_read_en    <= 1'b1;
                    rf_selrs1     <= req_rs1[RF_IDX_W*gidx +: RF_IDX_W];
                    rf_selrs2     <= req_rs2[RF_IDX_W*gidx +: RF_IDX_W];
                    rf_reg_select <= req_two[gidx];
                    rsp_id        <= gidx;
                end
                ISSUE: if (rf_complete || cnt == CW'(TO_CYC - 1)) begin
                    state         <= RESP;
                    rf_read_en    <= 1'b0;
                    rf_selrs1     <= '0;
                    rf_selrs2     <= '0;
                    rf_reg_select <= 1'b0;
                    rsp_valid     <= 1'b1;
                    rsp_err       <= !rf_complete;
                    rsp_data1     <= (!rf_complete || rf_selrs1 == '0) ? '0 : rf_data1;
                    rsp_data2     <= (!rf_complete || !rf_reg_select || rf_selrs2 == '0) ? '0 : rf_data2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_read_sched.sv
// tb_rf_read_sched: randomized scoreboard bench for rf_read_sched
module tb_rf_read_sched;
    localparam int N  = 4;
    localparam int TO = 4;

    typedef struct {
        int          id;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        err;
        int          at;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [5*N-1:0] req_rs1 = '0;
    logic [5*N-1:0] req_rs2 = '0;
    logic [N-1:0]  req_two = '0;
    logic [N-1:0]  req_ready;
    logic          rf_read_en;
    logic [4:0]    rf_selrs1;
    logic [4:0]    rf_selrs2;
    logic          rf_reg_select;
    logic [31:0]   rf_data1 = '0;
    logic [31:0]   rf_data2 = '0;
    logic          rf_complete = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_data1;
    logic [31:0]   rsp_data2;
    logic          rsp_err;
    logic          busy;

    rf_read_sched #(.NREQ(N), .TO_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_two(req_two),
        .req_ready(req_ready),
        .rf_read_en(rf_read_en), .rf_selrs1(rf_selrs1), .rf_selrs2(rf_selrs2),
        .rf_reg_select(rf_reg_select), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .rf_complete(rf_complete),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    exp_t q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // stimulus-side choices for the next accepted transaction
    int          nx_lat = 0;
    logic [31:0] nx_d1 = '0;
    logic [31:0] nx_d2 = '0;

    // reference model: one outstanding transaction, round-robin from the last winner
    int          last = N - 1;
    bit          busy_m = 0;
    int          hs_cyc, rsp_at, m_lat, pick;
    logic [4:0]  m_rs1, m_rs2;
    logic        m_two;
    logic [N-1:0] exp_rdy;
    bit          in_iss;
    exp_t        eb;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_zero", |{req_ready, rf_read_en, rf_selrs1, rf_selrs2, rf_reg_select,
                                rsp_valid, rsp_id, rsp_data1, rsp_data2, rsp_err, busy}, 0);
            busy_m = 0;
            last = N - 1;
            q.delete();
            rf_complete = 1'b0;
        end else begin
            exp_rdy = '0;
            pick = 0;
            if (!busy_m && req_valid != 0) begin
                for (int i = N; i >= 1; i--)
                    if (req_valid[(last + i) % N]) pick = (last + i) % N;
                exp_rdy[pick] = 1'b1;
            end
            in_iss = busy_m && cyc < rsp_at;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, busy_m);
            chk("rf_read_en", rf_read_en, in_iss);
            chk("rf_select", {rf_selrs1, rf_selrs2, rf_reg_select}, in_iss ? {m_rs1, m_rs2, m_two} : 11'd0);
            chk("rsp_valid", rsp_valid, busy_m && cyc >= rsp_at);
            rf_complete = in_iss ? (cyc - hs_cyc - 1 == m_lat) : 1'($urandom % 2);
            if (busy_m && cyc >= rsp_at && rsp_ready) begin
                busy_m = 0;
            end else if (!busy_m && req_valid != 0) begin
                last   = pick;
                busy_m = 1;
                hs_cyc = cyc;
                m_lat  = nx_lat;
                m_rs1  = req_rs1[pick*5 +: 5];
                m_rs2  = req_rs2[pick*5 +: 5];
                m_two  = req_two[pick];
                rf_data1 = nx_d1;
                rf_data2 = nx_d2;
                rsp_at = (m_lat < TO) ? cyc + 2 + m_lat : cyc + 1 + TO;
                eb.id  = pick;
                eb.err = m_lat >= TO;
                eb.d1  = (eb.err || m_rs1 == 0) ? 32'd0 : nx_d1;
                eb.d2  = (eb.err || m_rs2 == 0 || !m_two) ? 32'd0 : nx_d2;
                eb.at  = rsp_at;
                q.push_back(eb);
            end
        end
    end

    // monitor: checks stability under backpressure and pops on each accepted response
    bit          pv = 0, pacc = 0;
    int          first = 0;
    logic [1:0]  pid;
    logic [31:0] pd1, pd2;
    logic        perr;
    exp_t        ec;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 0;
            pacc = 0;
        end else begin
            if (rsp_valid) begin
                if (pv && !pacc) chk("rsp_stable", {rsp_id, rsp_data1, rsp_data2, rsp_err}, {pid, pd1, pd2, perr});
                else first = cyc;
                if (rsp_ready) begin
                    if (q.size() == 0) begin
                        chk("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        ec = q.pop_front();
                        chk("rsp_id", rsp_id, ec.id);
                        chk("rsp_data1", rsp_data1, ec.d1);
                        chk("rsp_data2", rsp_data2, ec.d2);
                        chk("rsp_err", rsp_err, ec.err);
                        chk("rsp_latency", first, ec.at);
                    end
                end
            end
            pv = rsp_valid;
            pacc = rsp_valid && rsp_ready;
            pid = rsp_id;
            pd1 = rsp_data1;
            pd2 = rsp_data2;
            perr = rsp_err;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < N; i++) begin
            req_rs1[5*i +: 5] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
            req_rs2[5*i +: 5] = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
            req_two[i] = 1'($urandom);
        end
        nx_d1 = $urandom;
        nx_d2 = $urandom;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        // single request with known data
        req_valid = 4'b0001;
        req_rs1[4:0] = 5'd5;
        req_rs2[4:0] = 5'd7;
        req_two[0] = 1'b1;
        nx_d1 = 32'h11;
        nx_d2 = 32'h22;
        nx_lat = 0;
        step(1);
        req_valid = '0;
        step(5);
        // masking: rs1 zero, second operand not wanted
        req_valid = 4'b0001;
        req_rs1[4:0] = 5'd0;
        req_rs2[4:0] = 5'd9;
        req_two[0] = 1'b0;
        nx_d1 = 32'hDEAD;
        nx_d2 = 32'hBEEF;
        step(1);
        req_valid = '0;
        step(5);
        // all requesters valid, back-to-back service
        rand_lanes();
        req_valid = 4'b1111;
        step(15);
        // backpressure
        rsp_ready = 1'b0;
        step(8);
        rsp_ready = 1'b1;
        step(6);
        // timeout: completion never arrives
        req_valid = '0;
        step(3);
        nx_lat = TO + 1;
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        step(10);
        // randomized traffic
        repeat (2000) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            nx_lat = $urandom % (TO + 2);
            rand_lanes();
            step(1);
        end
        // reset while a read is in ISSUE
        rsp_ready = 1'b1;
        nx_lat = TO + 1;
        req_valid = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (rf_read_en) break;
        end
        #2 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        nx_lat = 0;
        step(10);
        req_valid = '0;
        step(20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
